// File: rtl/debounce_sync.sv
// Input conditioner: N-stage synchronizer followed by a stability-counter debounce FSM.
// Define DEBOUNCE_EDGE_OUT_EN to add registered 1-cycle rise/fall strobes.
module debounce_sync #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned STABLE_CYCLES = 1000
) (
    input  logic clk,
    input  logic Reset,
    input  logic din,
    output logic dout,
    output logic busy
`ifdef DEBOUNCE_EDGE_OUT_EN
    ,
    output logic rise,
    output logic fall
`endif
);

    typedef enum logic [1:0] {
        StIdleLo,
        StChkHi,
        StIdleHi,
        StChkLo
    } state_e;

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ds;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dout_q, dout_d;

    // Only the last stage is ever observed; earlier stages may be metastable.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign ds = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= StIdleLo;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        unique case (state_q)
            StIdleLo: begin
                if (ds) begin
                    state_d = StChkHi;
                    cnt_d   = '0;
                end
            end
            StChkHi: begin
                if (!ds) begin
                    state_d = StIdleLo;
                    cnt_d   = '0;
                end else if (cnt_q == CntMax) begin
                    state_d = StIdleHi;
                    dout_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StIdleHi: begin
                if (!ds) begin
                    state_d = StChkLo;
                    cnt_d   = '0;
                end
            end
            StChkLo: begin
                if (ds) begin
                    state_d = StIdleHi;
                    cnt_d   = '0;
                end else if (cnt_q == CntMax) begin
                    state_d = StIdleLo;
                    dout_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdleLo;
                cnt_d   = '0;
                dout_d  = 1'b0;
            end
        endcase
    end

    assign dout = dout_q;
    assign busy = (state_q == StChkHi) || (state_q == StChkLo);

`ifdef DEBOUNCE_EDGE_OUT_EN
    logic rise_q, fall_q;

    // Strobes are registered on the same edge that updates dout.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= dout_d & ~dout_q;
            fall_q <= ~dout_d & dout_q;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Self-checking bench for debounce_sync: directed tables, hand sequences and a random run
// against a sliding-window model of the acceptance rule.
module tb_debounce_sync;

    localparam int unsigned SYNC   = 2;
    localparam int unsigned STABLE = 4;
    localparam int unsigned CW     = 3;

    logic clk = 1'b0;
    logic reset_n;
    logic din;
    logic dout;
    logic busy;
`ifdef DEBOUNCE_EDGE_OUT_EN
    logic rise;
    logic fall;
`endif

    debounce_sync #(
        .SYNC_STAGES  (SYNC),
        .CNT_W        (CW),
        .STABLE_CYCLES(STABLE)
    ) dut (
        .clk  (clk),
        .Reset(reset_n),
        .din  (din),
        .dout (dout),
        .busy (busy)
`ifdef DEBOUNCE_EDGE_OUT_EN
        ,
        .rise (rise),
        .fall (fall)
`endif
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_edges(input string name, input logic exp_rise, input logic exp_fall);
`ifdef DEBOUNCE_EDGE_OUT_EN
        check({name, ".rise"}, rise, exp_rise);
        check({name, ".fall"}, fall, exp_fall);
`else
        if (exp_rise && exp_fall) $display("note: %s both strobes expected", name);
`endif
    endtask

    // Reference: din as it stood at each active edge since the last reset.
    bit hist[$];
    bit m_dout, m_busy, m_rise, m_fall;

    function automatic bit hist_at(int idx);
        return (idx < 0) ? 1'b0 : hist[idx];
    endfunction

    // dout flips at edge k when the synchronized input disagreed with it on the last
    // STABLE+1 edges; busy means the current synchronized input disagrees with dout.
    task automatic model_edge(input bit d);
        int  k;
        bit  all_mis;
        bit  prev;
        hist.push_back(d);
        k = hist.size() - 1;
        all_mis = 1'b1;
        for (int j = 0; j <= int'(STABLE); j++)
            if (hist_at(k - int'(SYNC) - j) == m_dout) all_mis = 1'b0;
        prev = m_dout;
        if (all_mis) m_dout = ~m_dout;
        m_rise = ~prev & m_dout;
        m_fall = prev & ~m_dout;
        m_busy = hist_at(k - int'(SYNC)) != m_dout;
    endtask

    task automatic model_reset();
        hist.delete();
        m_dout = 1'b0;
        m_busy = 1'b0;
        m_rise = 1'b0;
        m_fall = 1'b0;
    endtask

    typedef struct {
        bit d;
        bit exp_dout;
        bit exp_busy;
        bit exp_rise;
        bit exp_fall;
    } vec_t;

    vec_t vecs[16];
    bit   saw_busy;
    int   hold;

    initial begin
        // Press then release; one entry per active edge, input applied before that edge.
        vecs[0]  = '{d: 1'b1, exp_dout: 1'b0, exp_busy: 1'b0, exp_rise: 1'b0, exp_fall: 1'b0};
        vecs[1]  = '{d: 1'b1, exp_dout: 1'b0, exp_busy: 1'b0, exp_rise: 1'b0, exp_fall: 1'b0};
        vecs[2]  = '{d: 1'b1, exp_dout: 1'b0, exp_busy: 1'b1, exp_rise: 1'b0, exp_fall: 1'b0};
        vecs[3]  = '{d: 1'b1, exp_dout: 1'b0, exp_busy: 1'b1, exp_rise: 1'b0, exp_fall: 1'b0};
        vecs[4]  = '{d: 1'b1, exp_dout: 1'b0, exp_busy: 1'b1, exp_rise: 1'b0, exp_fall: 1'b0};
        vecs[5]  = '{d: 1'b1, exp_dout: 1'b0, exp_busy: 1'b1, exp_rise: 1'b0, exp_fall: 1'b0};
        vecs[6]  = '{d: 1'b1, exp_dout: 1'b1, exp_busy: 1'b0, exp_rise: 1'b1, exp_fall: 1'b0};
        vecs[7]  = '{d: 1'b1, exp_dout: 1'b1, exp_busy: 1'b0, exp_rise: 1'b0, exp_fall: 1'b0};
        vecs[8]  = '{d: 1'b0, exp_dout: 1'b1, exp_busy: 1'b0, exp_rise: 1'b0, exp_fall: 1'b0};
        vecs[9]  = '{d: 1'b0, exp_dout: 1'b1, exp_busy: 1'b0, exp_rise: 1'b0, exp_fall: 1'b0};
        vecs[10] = '{d: 1'b0, exp_dout: 1'b1, exp_busy: 1'b1, exp_rise: 1'b0, exp_fall: 1'b0};
        vecs[11] = '{d: 1'b0, exp_dout: 1'b1, exp_busy: 1'b1, exp_rise: 1'b0, exp_fall: 1'b0};
        vecs[12] = '{d: 1'b0, exp_dout: 1'b1, exp_busy: 1'b1, exp_rise: 1'b0, exp_fall: 1'b0};
        vecs[13] = '{d: 1'b0, exp_dout: 1'b1, exp_busy: 1'b1, exp_rise: 1'b0, exp_fall: 1'b0};
        vecs[14] = '{d: 1'b0, exp_dout: 1'b0, exp_busy: 1'b0, exp_rise: 1'b0, exp_fall: 1'b1};
        vecs[15] = '{d: 1'b0, exp_dout: 1'b0, exp_busy: 1'b0, exp_rise: 1'b0, exp_fall: 1'b0};

        // Held in reset with a toggling input: everything stays quiet.
        reset_n = 1'b0;
        din     = 1'b1;
        #2;
        check("reset.dout", dout, 1'b0);
        check("reset.busy", busy, 1'b0);
        for (int i = 0; i < 8; i++) begin
            din = ~din;
            tick();
            check("reset_toggle.dout", dout, 1'b0);
            check("reset_toggle.busy", busy, 1'b0);
            check_edges("reset_toggle", 1'b0, 1'b0);
        end

        // Reset asserted while a rising candidate is being qualified.
        din     = 1'b1;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("mid_chk.busy_before", busy, 1'b1);
        #3 reset_n = 1'b0;
        #1;
        check("mid_chk.async_busy", busy, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("mid_chk.dout", dout, 1'b0);
            check_edges("mid_chk", 1'b0, 1'b0);
        end
        din     = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("post_reset.dout", dout, 1'b0);
            check_edges("post_reset", 1'b0, 1'b0);
        end

        // Clean press and release.
        for (int i = 0; i < 16; i++) begin
            din = vecs[i].d;
            tick();
            check($sformatf("vec%0d.dout", i), dout, vecs[i].exp_dout);
            check($sformatf("vec%0d.busy", i), busy, vecs[i].exp_busy);
            check_edges($sformatf("vec%0d", i), vecs[i].exp_rise, vecs[i].exp_fall);
        end

        // Bounce: 3 high, 2 low, then held high; the counter must start over.
        for (int i = 0; i < 3; i++) begin
            din = 1'b1;
            tick();
            check("bounce_hi.dout", dout, 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            din = 1'b0;
            tick();
            check("bounce_lo.dout", dout, 1'b0);
            check_edges("bounce_lo", 1'b0, 1'b0);
        end
        din = 1'b1;
        for (int i = 0; i <= 7; i++) begin
            tick();
            check($sformatf("bounce_final%0d.dout", i), dout, i >= 6);
            check_edges($sformatf("bounce_final%0d", i), i == 6, 1'b0);
        end
        for (int i = 0; i < 3; i++) tick();

        // Low glitch of exactly STABLE clocks while high: rejected.
        saw_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            din = 1'b0;
            tick();
            saw_busy |= busy;
            check("glitch4.dout", dout, 1'b1);
            check_edges("glitch4", 1'b0, 1'b0);
        end
        din = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            saw_busy |= busy;
            check("glitch4_after.dout", dout, 1'b1);
            check_edges("glitch4_after", 1'b0, 1'b0);
        end
        check("glitch4.busy_seen", saw_busy, 1'b1);
        check("glitch4.busy_clear", busy, 1'b0);

        // Low for STABLE+1 clocks: accepted at the sixth edge.
        for (int i = 0; i <= 6; i++) begin
            din = (i < 5) ? 1'b0 : 1'b1;
            tick();
            check($sformatf("glitch5_%0d.dout", i), dout, i < 6);
            check_edges($sformatf("glitch5_%0d", i), 1'b0, i == 6);
        end
        for (int i = 0; i < 12; i++) tick();

        // Random run against the window model, with occasional asynchronous resets.
        reset_n = 1'b0;
        #2;
        model_reset();
        tick();
        reset_n = 1'b1;
        hold = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (hold == 0) begin
                din  = 1'($urandom_range(0, 1));
                hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12))
                                                   : int'($urandom_range(1, 6));
            end
            hold--;
            tick();
            model_edge(din);
            check("rand.dout", dout, m_dout);
            check("rand.busy", busy, m_busy);
            check_edges("rand", m_rise, m_fall);
            if ($urandom_range(0, 399) == 0) begin
                #2 reset_n = 1'b0;
                #1;
                check("rand_reset.dout", dout, 1'b0);
                check("rand_reset.busy", busy, 1'b0);
                model_reset();
                tick();
                tick();
                reset_n = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
